// File: rtl/y86_regfile_mp.sv
// Y86-64 register file: two combinational read ports, two write ports (M beats E),
// and a one-bit-per-register pending-write scoreboard for hazard detection.
module y86_regfile_mp #(
  parameter int               WIDTH    = 64,
  parameter int               NREGS    = 15,
  parameter int               RSP_IDX  = 4,
  parameter logic [WIDTH-1:0] RSP_INIT = '0,
  parameter bit               BYPASS   = 1'b1
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [3:0]             srcA,
  input  logic [3:0]             srcB,
  output logic [WIDTH-1:0]       valA,
  output logic [WIDTH-1:0]       valB,
  output logic                   rdyA,
  output logic                   rdyB,
  input  logic [3:0]             dstE,
  input  logic [WIDTH-1:0]       valE,
  input  logic [3:0]             dstM,
  input  logic [WIDTH-1:0]       valM,
  input  logic                   rsv_en,
  input  logic [3:0]             rsv_idx,
  output logic [NREGS-1:0]       pending,
  output logic [NREGS*WIDTH-1:0] regs_flat
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] pending_q, pending_d;
  logic             we_e, we_m, rsv_ok;

  // Any index at or above NREGS (RNONE included) is inert on every port.
  function automatic logic idx_ok(input logic [3:0] idx);
    return {28'd0, idx} < 32'(NREGS);
  endfunction

  assign we_e   = idx_ok(dstE);
  assign we_m   = idx_ok(dstM);
  assign rsv_ok = rsv_en && idx_ok(rsv_idx);

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i]    = regs_q[i];
      pending_d[i] = pending_q[i];
      if (we_m && dstM == 4'(i))      regs_d[i] = valM;
      else if (we_e && dstE == 4'(i)) regs_d[i] = valE;
      if ((we_m && dstM == 4'(i)) || (we_e && dstE == 4'(i))) pending_d[i] = 1'b0;
      // A new reservation outranks the retiring write of the previous producer.
      if (rsv_ok && rsv_idx == 4'(i)) pending_d[i] = 1'b1;
    end
  end

  // NOTE: every architectural register is reset explicitly; software relies on
  // defined values, so this array cannot be left to power-up contents.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= (i == RSP_IDX) ? RSP_INIT : '0;
      pending_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all state updating from pre-edge values.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      pending_q <= pending_d;
    end
  end

  function automatic logic [WIDTH-1:0] rd_val(input logic [3:0] src);
    if (!idx_ok(src))                  return '0;
    if (BYPASS && we_m && src == dstM) return valM;
    if (BYPASS && we_e && src == dstE) return valE;
    return regs_q[src];
  endfunction

  function automatic logic rd_rdy(input logic [3:0] src);
    if (!idx_ok(src)) return 1'b1;
    if (BYPASS && ((we_m && src == dstM) || (we_e && src == dstE))) return 1'b1;
    return !pending_q[src];
  endfunction

  always_comb begin
    valA = rd_val(srcA);
    valB = rd_val(srcB);
    rdyA = rd_rdy(srcA);
    rdyB = rd_rdy(srcB);
  end

  assign pending = pending_q;

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[g*WIDTH +: WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_y86_regfile_mp.sv
// Bench for y86_regfile_mp: bypassing and non-bypassing instances share stimulus and
// are compared every cycle against an array-based architectural model.
module tb_y86_regfile_mp;
  localparam int N = 15;
  localparam int W = 64;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [3:0]   srcA, srcB, dstE, dstM, rsv_idx;
  logic [W-1:0] valE, valM;
  logic         rsv_en;

  logic [W-1:0]   valA_b, valB_b, valA_n, valB_n;
  logic           rdyA_b, rdyB_b, rdyA_n, rdyB_n;
  logic [N-1:0]   pend_b, pend_n;
  logic [N*W-1:0] flat_b, flat_n;

  y86_regfile_mp #(.WIDTH(W), .NREGS(N), .RSP_IDX(4), .RSP_INIT(64'h200), .BYPASS(1'b1)) u_byp (
    .Clk(Clk), .Rst(Rst), .srcA(srcA), .srcB(srcB), .valA(valA_b), .valB(valB_b),
    .rdyA(rdyA_b), .rdyB(rdyB_b), .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .rsv_en(rsv_en), .rsv_idx(rsv_idx), .pending(pend_b), .regs_flat(flat_b));

  y86_regfile_mp #(.WIDTH(W), .NREGS(N), .RSP_IDX(4), .RSP_INIT(64'h200), .BYPASS(1'b0)) u_nob (
    .Clk(Clk), .Rst(Rst), .srcA(srcA), .srcB(srcB), .valA(valA_n), .valB(valB_n),
    .rdyA(rdyA_n), .rdyB(rdyB_n), .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .rsv_en(rsv_en), .rsv_idx(rsv_idx), .pending(pend_n), .regs_flat(flat_n));

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  logic [W-1:0] m_r [N];
  bit           m_p [N];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit real_reg(input logic [3:0] idx);
    return int'(idx) < N;
  endfunction

  function automatic logic [W-1:0] exp_val(input logic [3:0] src, input bit byp);
    if (!real_reg(src)) return '0;
    if (byp && src == dstM) return valM;
    if (byp && src == dstE) return valE;
    return m_r[src];
  endfunction

  function automatic logic exp_rdy(input logic [3:0] src, input bit byp);
    if (!real_reg(src)) return 1'b1;
    if (byp && (src == dstM || src == dstE)) return 1'b1;
    return !m_p[src];
  endfunction

  function automatic logic [W-1:0] exp_pend();
    logic [W-1:0] p = '0;
    for (int i = 0; i < N; i++) p[i] = m_p[i];
    return p;
  endfunction

  // Architectural update applied at each rising edge.
  task automatic model_edge();
    if (Rst) begin
      for (int i = 0; i < N; i++) begin
        m_r[i] = (i == 4) ? 64'h200 : 64'h0;
        m_p[i] = 1'b0;
      end
    end else begin
      if (real_reg(dstE)) begin m_r[dstE] = valE; m_p[dstE] = 1'b0; end
      if (real_reg(dstM)) begin m_r[dstM] = valM; m_p[dstM] = 1'b0; end
      if (rsv_en && real_reg(rsv_idx)) m_p[rsv_idx] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0; rsv_en = 1'b0; rsv_idx = 4'hF;
  endtask

  always @(negedge Clk) begin
    if (checking) begin
      check("valA_byp", valA_b, exp_val(srcA, 1'b1));
      check("valB_byp", valB_b, exp_val(srcB, 1'b1));
      check("rdyA_byp", {63'd0, rdyA_b}, {63'd0, exp_rdy(srcA, 1'b1)});
      check("rdyB_byp", {63'd0, rdyB_b}, {63'd0, exp_rdy(srcB, 1'b1)});
      check("valA_nob", valA_n, exp_val(srcA, 1'b0));
      check("valB_nob", valB_n, exp_val(srcB, 1'b0));
      check("rdyA_nob", {63'd0, rdyA_n}, {63'd0, exp_rdy(srcA, 1'b0)});
      check("rdyB_nob", {63'd0, rdyB_n}, {63'd0, exp_rdy(srcB, 1'b0)});
      check("pend_byp", {49'd0, pend_b}, exp_pend());
      check("pend_nob", {49'd0, pend_n}, exp_pend());
      for (int i = 0; i < N; i++) begin
        check($sformatf("reg%0d_byp", i), flat_b[i*W +: W], m_r[i]);
        check($sformatf("reg%0d_nob", i), flat_n[i*W +: W], m_r[i]);
      end
    end
  end

  initial begin
    Rst = 1'b1; srcA = 4'hF; srcB = 4'hF; idle();
    tick();
    Rst = 1'b0; checking = 1'b1;

    // Reset state
    check("t1_r4", flat_b[4*W +: W], 64'h200);
    check("t1_r0", flat_n[0 +: W], 64'h0);
    check("t1_pend", {49'd0, pend_b}, 64'h0);
    check("t1_rdy", {62'd0, rdyA_b, rdyB_n}, 64'h3);

    // Plain E write, stored-vs-bypass read
    dstE = 4'd2; valE = 64'h3; tick();
    dstE = 4'd2; valE = 64'h5; srcA = 4'd2;
    #1;
    check("t2_byp_same", valA_b, 64'h5);
    check("t2_nob_same", valA_n, 64'h3);
    tick(); idle();
    #1;
    check("t2_nob_next", valA_n, 64'h5);

    // popq %rsp: M wins on a shared destination
    dstE = 4'd4; valE = 64'h1F8; dstM = 4'd4; valM = 64'h77; srcA = 4'd4; srcB = 4'd2;
    #1;
    check("t3_byp", valA_b, 64'h77);
    check("t3_nob", valA_n, 64'h200);
    tick(); idle();
    check("t3_r4", flat_n[4*W +: W], 64'h77);

    // Scoreboard
    rsv_en = 1'b1; rsv_idx = 4'd3; tick(); idle();
    srcA = 4'd3;
    #1;
    check("t4_pend3", {63'd0, pend_b[3]}, 64'h1);
    check("t4_rdy_nob", {63'd0, rdyA_n}, 64'h0);
    dstM = 4'd3; valM = 64'h9;
    #1;
    check("t4_rdy_byp", {63'd0, rdyA_b}, 64'h1);
    check("t4_val_byp", valA_b, 64'h9);
    check("t4_rdy_nob_w", {63'd0, rdyA_n}, 64'h0);
    tick(); idle();
    check("t4_clr", {63'd0, pend_n[3]}, 64'h0);
    rsv_en = 1'b1; rsv_idx = 4'd3; dstE = 4'd3; valE = 64'h11; tick(); idle();
    check("t4_setwins", {63'd0, pend_b[3]}, 64'h1);
    check("t4_r3", flat_b[3*W +: W], 64'h11);

    // RNONE inert on every port; index 15 never touches R14
    dstE = 4'd14; valE = 64'h14; tick(); idle();
    srcA = 4'hF; srcB = 4'd14; dstE = 4'hF; valE = 64'hDEAD; dstM = 4'hF; valM = 64'hBEEF;
    rsv_en = 1'b1; rsv_idx = 4'hF;
    #1;
    check("t5_valA", valA_b, 64'h0);
    check("t5_rdyA", {63'd0, rdyA_b}, 64'h1);
    tick(); idle();
    check("t5_r14", flat_b[14*W +: W], 64'h14);
    check("t5_pend", {49'd0, pend_n}, 64'h8);

    // Mid-stream reset discards writes and reservations
    dstE = 4'd1; valE = 64'hAA; tick(); idle();
    check("t6_r1", flat_b[1*W +: W], 64'hAA);
    rsv_en = 1'b1; rsv_idx = 4'd5; tick(); idle();
    Rst = 1'b1; dstE = 4'd1; valE = 64'hBB; rsv_en = 1'b1; rsv_idx = 4'd6; tick();
    Rst = 1'b0; idle();
    check("t6_r1_rst", flat_b[1*W +: W], 64'h0);
    check("t6_pend", {49'd0, pend_b}, 64'h0);
    check("t6_r4", flat_n[4*W +: W], 64'h200);

    // Mixed traffic, checked each cycle by the compare process
    for (int k = 0; k < 200; k++) begin
      srcA = 4'($urandom_range(0, 15)); srcB = 4'($urandom_range(0, 15));
      dstE = 4'($urandom_range(0, 15)); dstM = 4'($urandom_range(0, 15));
      valE = {$urandom, $urandom}; valM = {$urandom, $urandom};
      rsv_en = 1'($urandom_range(0, 1)); rsv_idx = 4'($urandom_range(0, 15));
      Rst = (k == 120);
      tick();
    end
    Rst = 1'b0; idle();
    @(negedge Clk);
    checking = 1'b0;
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
